// File: rtl/bubble_sort_if.sv
// Host-side bus of the bubble sort engine: load port, read-back port, control and status.
interface bubble_sort_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             start;
    logic             descend;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] swap_cnt;
    logic [CNT_W-1:0] pass_cnt;

    modport master (
        output start, descend, ld_en, ld_addr, ld_data, rd_addr,
        input  rd_data, busy, done, swap_cnt, pass_cnt
    );

    modport slave (
        input  start, descend, ld_en, ld_addr, ld_data, rd_addr,
        output rd_data, busy, done, swap_cnt, pass_cnt
    );
endinterface

// File: rtl/bubble_sort_engine.sv
// In-place bubble sorter over a DEPTH-entry register array with early exit on a swap-free pass.
// Swap and pass counters are kept for performance monitoring.
module bubble_sort_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    bubble_sort_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        StIdle, StInit, StRd1, StRd2, StCmp, StWr1, StWr2, StNext, StPassEnd, StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    lim_q, j_q;
    logic             swapped_q, dir_q, busy_q, done_q;
    logic [WIDTH-1:0] r1_q, r2_q;
    logic [CNT_W-1:0] swap_cnt_q, pass_cnt_q;

    logic [AW-1:0] j_inc, lim_dec;
    logic          swap, ld_ok, rd_ok;

    assign j_inc   = j_q + 1'b1;
    assign lim_dec = lim_q - 1'b1;
    // Strict compares: equal keys never swap, keeping the sort stable.
    assign swap    = dir_q ? (r1_q < r2_q) : (r1_q > r2_q);

    // Address range checks only matter when DEPTH leaves unused codes in AW bits.
    if (DEPTH == (1 << AW)) begin : g_full_range
        assign ld_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_part_range
        assign ld_ok = 32'(bus.ld_addr) < DEPTH;
        assign rd_ok = 32'(bus.rd_addr) < DEPTH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lim_q      <= '0;
            j_q        <= '0;
            swapped_q  <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            r1_q       <= '0;
            r2_q       <= '0;
            swap_cnt_q <= '0;
            pass_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.ld_en && !busy_q && ld_ok) mem_q[bus.ld_addr] <= bus.ld_data;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        dir_q   <= bus.descend;
                        busy_q  <= 1'b1;
                        state_q <= StInit;
                    end
                end
                StInit: begin
                    lim_q      <= AW'(DEPTH - 1);
                    j_q        <= '0;
                    swapped_q  <= 1'b0;
                    swap_cnt_q <= '0;
                    pass_cnt_q <= CNT_W'(1);
                    state_q    <= StRd1;
                end
                StRd1: begin
                    r1_q    <= mem_q[j_q];
                    state_q <= StRd2;
                end
                StRd2: begin
                    r2_q    <= mem_q[j_inc];
                    state_q <= StCmp;
                end
                StCmp: state_q <= swap ? StWr1 : StNext;
                StWr1: begin
                    mem_q[j_q] <= r2_q;
                    state_q    <= StWr2;
                end
                StWr2: begin
                    mem_q[j_inc] <= r1_q;
                    swapped_q    <= 1'b1;
                    if (swap_cnt_q != '1) swap_cnt_q <= swap_cnt_q + 1'b1;
                    state_q      <= StNext;
                end
                StNext: begin
                    if (j_q == lim_dec) begin
                        state_q <= StPassEnd;
                    end else begin
                        j_q     <= j_inc;
                        state_q <= StRd1;
                    end
                end
                StPassEnd: begin
                    if (!swapped_q || lim_q == AW'(1)) begin
                        state_q <= StDone;
                    end else begin
                        lim_q      <= lim_dec;
                        j_q        <= '0;
                        swapped_q  <= 1'b0;
                        pass_cnt_q <= pass_cnt_q + 1'b1;
                        state_q    <= StRd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.rd_data  = rd_ok ? mem_q[bus.rd_addr] : '0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.swap_cnt = swap_cnt_q;
    assign bus.pass_cnt = pass_cnt_q;
endmodule
